// File: rtl/keypad_code_matcher.sv
// keypad_code_matcher
// Encodes a one-hot keypad into a BCD digit and a valid flag. Each new key
// press is shifted into either the user-input (UI) or the set-point (SP) code
// register. The block then reports whether the two codes are equal.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   key_in[KEYS-1:0]    keypad lines, bit i = key i
//   sel                 press routing: 1 = UI register, 0 = SP register
//   clr_ui, clr_sp      synchronous clears of a code register and its count
//   enc_out[4:0]        combinational {valid, bcd}
//   mode_out[1:0]       combinational {valid & ~sel, valid & sel}
//   ui_code, sp_code    packed digits, oldest digit in the top nibble
//   ui_count, sp_count  digits entered, saturating at DIGITS
//   match, match_valid  registered code equality / both registers full
module keypad_code_matcher #(
   parameter int unsigned DIGITS = 8,
   parameter int unsigned KEYS   = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [KEYS-1:0]       key_in,
   input  logic                  sel,
   input  logic                  clr_ui,
   input  logic                  clr_sp,
   output logic [4:0]            enc_out,
   output logic [1:0]            mode_out,
   output logic [4*DIGITS-1:0]   ui_code,
   output logic [4*DIGITS-1:0]   sp_code,
   output logic [3:0]            ui_count,
   output logic [3:0]            sp_count,
   output logic                  match,
   output logic                  match_valid
);

   localparam int unsigned CODE_W = 4 * DIGITS;
   localparam int unsigned BCD_W  = 4;
   localparam int unsigned CNT_W  = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGITS);

   logic              key_valid;
   logic [BCD_W-1:0]  key_bcd;
   logic              valid_q;
   logic              press;
   logic [CODE_W-1:0] ui_code_nx, sp_code_nx;
   logic [CNT_W-1:0]  ui_count_nx, sp_count_nx;

   // Priority encoder: the highest-numbered pressed key wins.
   always_comb begin
      key_bcd   = '0;
      key_valid = |key_in;
      for (int unsigned i = 0; i < KEYS; i++) begin
         if (key_in[i]) key_bcd = BCD_W'(i);
      end
   end

   assign enc_out  = {key_valid, key_bcd};
   assign mode_out = {key_valid & ~sel, key_valid & sel};

   // Rising edge of valid: a held key or a priority change mid-hold gives no new press.
   assign press = key_valid & ~valid_q;

   // Next-state code and count; a clear beats a press to the same register.
   always_comb begin
      ui_code_nx  = ui_code;
      sp_code_nx  = sp_code;
      ui_count_nx = ui_count;
      sp_count_nx = sp_count;

      if (clr_ui) begin
         ui_code_nx  = '0;
         ui_count_nx = '0;
      end else if (press && sel) begin
         ui_code_nx = {ui_code[CODE_W-BCD_W-1:0], key_bcd};
         if (ui_count != CNT_MAX) ui_count_nx = ui_count + CNT_W'(1);
      end

      if (clr_sp) begin
         sp_code_nx  = '0;
         sp_count_nx = '0;
      end else if (press && !sel) begin
         sp_code_nx = {sp_code[CODE_W-BCD_W-1:0], key_bcd};
         if (sp_count != CNT_MAX) sp_count_nx = sp_count + CNT_W'(1);
      end
   end

   // State and comparator registers; comparison uses next-state values so
   // match/match_valid line up with the codes they describe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q     <= 1'b0;
         ui_code     <= '0;
         sp_code     <= '0;
         ui_count    <= '0;
         sp_count    <= '0;
         match       <= 1'b1;
         match_valid <= 1'b0;
      end else begin
         valid_q     <= key_valid;
         ui_code     <= ui_code_nx;
         sp_code     <= sp_code_nx;
         ui_count    <= ui_count_nx;
         sp_count    <= sp_count_nx;
         match       <= (ui_code_nx == sp_code_nx);
         match_valid <= (ui_count_nx == CNT_MAX) && (sp_count_nx == CNT_MAX);
      end
   end

endmodule

// File: tb/tb_keypad_code_matcher.sv
// Directed testbench for keypad_code_matcher. Inputs change on the falling
// edge and outputs are sampled on the falling edge, away from the active edge.
module tb_keypad_code_matcher;

   logic        clk;
   logic        rst_n;
   logic [9:0]  key_in;
   logic        sel;
   logic        clr_ui;
   logic        clr_sp;
   logic [4:0]  enc_out;
   logic [1:0]  mode_out;
   logic [31:0] ui_code;
   logic [31:0] sp_code;
   logic [3:0]  ui_count;
   logic [3:0]  sp_count;
   logic        match;
   logic        match_valid;

   int tests_run    = 0;
   int tests_failed = 0;

   keypad_code_matcher #(.DIGITS(8), .KEYS(10)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_in      (key_in),
      .sel         (sel),
      .clr_ui      (clr_ui),
      .clr_sp      (clr_sp),
      .enc_out     (enc_out),
      .mode_out    (mode_out),
      .ui_code     (ui_code),
      .sp_code     (sp_code),
      .ui_count    (ui_count),
      .sp_count    (sp_count),
      .match       (match),
      .match_valid (match_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [9:0] key(input int d);
      logic [9:0] one;
      one = 10'd1;
      return one << d;
   endfunction

   // Press: drive at a falling edge, hold for 3 rising edges, release for 2.
   task automatic do_press(input logic [9:0] k, input logic s,
                           output logic [4:0] enc_seen, output logic [1:0] mode_seen);
      @(negedge clk);
      key_in = k;
      sel    = s;
      #1;
      enc_seen  = enc_out;
      mode_seen = mode_out;
      repeat (3) @(negedge clk);
      key_in = '0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; key_in = '0; sel = 1'b0; clr_ui = 1'b0; clr_sp = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++;
      if (ui_code !== 32'h0 || sp_code !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_codes ui=%h sp=%h expected 0/0", ui_code, sp_code);
      end
      tests_run++;
      if (ui_count !== 4'd0 || sp_count !== 4'd0) begin
         tests_failed++;
         $display("FAIL reset_counts ui=%0d sp=%0d expected 0/0", ui_count, sp_count);
      end
      tests_run++;
      if (match !== 1'b1 || match_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_match match=%b mv=%b expected 1/0", match, match_valid);
      end
      tests_run++;
      if (enc_out !== 5'b0_0000 || mode_out !== 2'b00) begin
         tests_failed++;
         $display("FAIL idle_enc enc=%b mode=%b expected 00000/00", enc_out, mode_out);
      end
   endtask

   task automatic test_ui_entry();
      int digs[8] = '{2, 1, 9, 3, 5, 4, 8, 8};
      logic [31:0] exp_code;
      logic [4:0]  e;
      logic [1:0]  m;
      exp_code = 32'h0;
      for (int i = 0; i < 8; i++) begin
         do_press(key(digs[i]), 1'b1, e, m);
         exp_code = {exp_code[27:0], 4'(digs[i])};
         tests_run++;
         if (m !== 2'b01 || e !== {1'b1, 4'(digs[i])}) begin
            tests_failed++;
            $display("FAIL ui_enc_mode[%0d] enc=%b mode=%b expected %b/01",
                     i, e, m, {1'b1, 4'(digs[i])});
         end
         tests_run++;
         if (ui_code !== exp_code || ui_count !== 4'(i + 1)) begin
            tests_failed++;
            $display("FAIL ui_shift[%0d] code=%h cnt=%0d expected %h/%0d",
                     i, ui_code, ui_count, exp_code, i + 1);
         end
      end
      tests_run++;
      if (ui_code !== 32'h21935488 || match !== 1'b0 || match_valid !== 1'b0 || sp_code !== 32'h0) begin
         tests_failed++;
         $display("FAIL ui_final ui=%h sp=%h match=%b mv=%b expected 21935488/0/0/0",
                  ui_code, sp_code, match, match_valid);
      end
   endtask

   task automatic test_sp_entry();
      int digs[8] = '{2, 1, 9, 3, 5, 4, 8, 8};
      logic [4:0] e;
      logic [1:0] m;
      logic       mode_ok;
      mode_ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         do_press(key(digs[i]), 1'b0, e, m);
         if (m !== 2'b10) mode_ok = 1'b0;
      end
      tests_run++;
      if (!mode_ok) begin
         tests_failed++;
         $display("FAIL sp_mode last mode=%b expected 10", m);
      end
      tests_run++;
      if (sp_code !== 32'h21935488 || sp_count !== 4'd8) begin
         tests_failed++;
         $display("FAIL sp_final code=%h cnt=%0d expected 21935488/8", sp_code, sp_count);
      end
      tests_run++;
      if (match !== 1'b1 || match_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL sp_match match=%b mv=%b expected 1/1", match, match_valid);
      end
   endtask

   task automatic test_sp_overflow();
      logic [4:0] e;
      logic [1:0] m;
      do_press(key(7), 1'b0, e, m);
      tests_run++;
      if (sp_code !== 32'h19354887 || sp_count !== 4'd8 || match !== 1'b0 || match_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL sp_ovf7 code=%h cnt=%0d match=%b mv=%b expected 19354887/8/0/1",
                  sp_code, sp_count, match, match_valid);
      end
      do_press(key(0), 1'b0, e, m);
      tests_run++;
      if (e !== 5'b1_0000) begin
         tests_failed++;
         $display("FAIL key0_enc enc=%b expected 10000", e);
      end
      tests_run++;
      if (sp_code !== 32'h93548870 || sp_count !== 4'd8 || match !== 1'b0 || match_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL sp_ovf0 code=%h cnt=%0d match=%b mv=%b expected 93548870/8/0/1",
                  sp_code, sp_count, match, match_valid);
      end
   endtask

   task automatic test_priority();
      logic [4:0] e;
      logic [1:0] m;
      do_press(key(9) | key(2), 1'b0, e, m);
      tests_run++;
      if (e !== 5'b1_1001 || sp_code !== 32'h35488709) begin
         tests_failed++;
         $display("FAIL prio_two_keys enc=%b sp=%h expected 11001/35488709", e, sp_code);
      end
      // Key 2 held, then key 9 added: still one press, digit 2.
      @(negedge clk); key_in = key(2); sel = 1'b0;
      @(negedge clk); key_in = key(9) | key(2);
      #1;
      tests_run++;
      if (enc_out !== 5'b1_1001) begin
         tests_failed++;
         $display("FAIL prio_change_enc enc=%b expected 11001", enc_out);
      end
      repeat (2) @(negedge clk);
      key_in = '0;
      repeat (2) @(negedge clk);
      tests_run++;
      if (sp_code !== 32'h54887092) begin
         tests_failed++;
         $display("FAIL prio_change_shift sp=%h expected 54887092", sp_code);
      end
      // sel flipped while key 4 is held: press already went to UI.
      @(negedge clk); key_in = key(4); sel = 1'b1;
      @(negedge clk); sel = 1'b0;
      repeat (2) @(negedge clk);
      key_in = '0;
      repeat (2) @(negedge clk);
      tests_run++;
      if (ui_code !== 32'h19354884 || sp_code !== 32'h54887092 || ui_count !== 4'd8) begin
         tests_failed++;
         $display("FAIL sel_change ui=%h sp=%h ucnt=%0d expected 19354884/54887092/8",
                  ui_code, sp_code, ui_count);
      end
   endtask

   task automatic test_clear();
      logic [4:0] e;
      logic [1:0] m;
      @(negedge clk); clr_ui = 1'b1;
      @(negedge clk); clr_ui = 1'b0;
      tests_run++;
      if (ui_code !== 32'h0 || ui_count !== 4'd0 || match_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL clr_ui code=%h cnt=%0d mv=%b expected 0/0/0", ui_code, ui_count, match_valid);
      end
      do_press(key(1), 1'b1, e, m);
      do_press(key(2), 1'b1, e, m);
      do_press(key(3), 1'b1, e, m);
      tests_run++;
      if (ui_code !== 32'h00000123 || ui_count !== 4'd3) begin
         tests_failed++;
         $display("FAIL ui_partial code=%h cnt=%0d expected 00000123/3", ui_code, ui_count);
      end
      // Clear with a simultaneous press to UI: press is lost.
      @(negedge clk); key_in = key(5); sel = 1'b1; clr_ui = 1'b1;
      @(negedge clk); clr_ui = 1'b0;
      tests_run++;
      if (ui_code !== 32'h0 || ui_count !== 4'd0 || sp_code !== 32'h54887092 || sp_count !== 4'd8) begin
         tests_failed++;
         $display("FAIL clr_vs_press ui=%h ucnt=%0d sp=%h scnt=%0d expected 0/0/54887092/8",
                  ui_code, ui_count, sp_code, sp_count);
      end
      // Key still held after the clear: no second press.
      @(negedge clk);
      tests_run++;
      if (ui_code !== 32'h0 || ui_count !== 4'd0) begin
         tests_failed++;
         $display("FAIL clr_hold code=%h cnt=%0d expected 0/0", ui_code, ui_count);
      end
      key_in = '0;
      repeat (2) @(negedge clk);
      // SP clear while a press goes to UI.
      @(negedge clk); key_in = key(6); sel = 1'b1; clr_sp = 1'b1;
      @(negedge clk); clr_sp = 1'b0;
      tests_run++;
      if (sp_code !== 32'h0 || sp_count !== 4'd0 || ui_code !== 32'h6 || ui_count !== 4'd1 || match !== 1'b0) begin
         tests_failed++;
         $display("FAIL clr_sp_press_ui sp=%h scnt=%0d ui=%h ucnt=%0d match=%b expected 0/0/6/1/0",
                  sp_code, sp_count, ui_code, ui_count, match);
      end
      key_in = '0;
      repeat (2) @(negedge clk);
      @(negedge clk); clr_ui = 1'b1; clr_sp = 1'b1;
      @(negedge clk); clr_ui = 1'b0; clr_sp = 1'b0;
      tests_run++;
      if (match !== 1'b1 || match_valid !== 1'b0 || ui_code !== 32'h0) begin
         tests_failed++;
         $display("FAIL clr_both match=%b mv=%b ui=%h expected 1/0/0", match, match_valid, ui_code);
      end
   endtask

   task automatic test_reset_mid();
      logic [4:0] e;
      logic [1:0] m;
      do_press(key(7), 1'b0, e, m);
      do_press(key(7), 1'b1, e, m);
      tests_run++;
      if (ui_code !== 32'h7 || sp_code !== 32'h7 || match !== 1'b1) begin
         tests_failed++;
         $display("FAIL pre_reset ui=%h sp=%h match=%b expected 7/7/1", ui_code, sp_code, match);
      end
      // Reset together with a press and a clear: reset wins.
      @(negedge clk); key_in = key(3); sel = 1'b1; clr_sp = 1'b1; rst_n = 1'b0;
      @(negedge clk); key_in = '0; clr_sp = 1'b0; rst_n = 1'b1;
      tests_run++;
      if (ui_code !== 32'h0 || sp_code !== 32'h0 || ui_count !== 4'd0 || sp_count !== 4'd0) begin
         tests_failed++;
         $display("FAIL mid_reset ui=%h sp=%h ucnt=%0d scnt=%0d expected 0/0/0/0",
                  ui_code, sp_code, ui_count, sp_count);
      end
      tests_run++;
      if (match !== 1'b1 || match_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_reset_match match=%b mv=%b expected 1/0", match, match_valid);
      end
   endtask

   initial begin
      test_reset();
      test_ui_entry();
      test_sp_entry();
      test_sp_overflow();
      test_priority();
      test_clear();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
